// File: rtl/fir_sequencer_if.sv
// Control/status bundle between a FIR sequencer and its controller.
// The controller drives start/stop; the sequencer drives FIR enables and status.
interface fir_sequencer_if #(
  parameter int OS_FACTOR = 4
) ();
  localparam int PW = $clog2(OS_FACTOR);

  logic          i_start;
  logic          i_stop;
  logic          o_fir_en;
  logic          o_zero_in;
  logic          o_valid;
  logic [PW-1:0] o_phase;
  logic          o_strobe;
  logic          o_busy;

  modport master (
    output i_start,
    output i_stop,
    input  o_fir_en,
    input  o_zero_in,
    input  o_valid,
    input  o_phase,
    input  o_strobe,
    input  o_busy
  );

  modport slave (
    input  i_start,
    input  i_stop,
    output o_fir_en,
    output o_zero_in,
    output o_valid,
    output o_phase,
    output o_strobe,
    output o_busy
  );
endinterface

// File: rtl/fir_sequencer.sv
// Sequences a pipelined FIR through fill, run and zero-flush phases.
// Tracks the oversampling phase and flags decimation strobes.
module fir_sequencer #(
  parameter int NUM_COEFF = 17,
  parameter int PIPE_LAT  = 5,
  parameter int OS_FACTOR = 4
) (
  input  logic clk,
  input  logic i_reset,
  fir_sequencer_if.slave bus
);
  localparam int CW = $clog2(NUM_COEFF + PIPE_LAT) + 1;
  localparam int PW = $clog2(OS_FACTOR);

  localparam logic [CW-1:0] FILL_END  = CW'(PIPE_LAT - 1);
  localparam logic [CW-1:0] FLUSH_END = CW'(NUM_COEFF + PIPE_LAT - 2);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.i_start) state_d = FILL;
      end
      FILL: begin
        if (bus.i_stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == FILL_END) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (bus.i_stop) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == FLUSH_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Phase starts at 0 on the first enabled cycle and wraps naturally.
  always_comb begin
    phase_d = phase_q + PW'(1);
    if (state_d == IDLE || state_q == IDLE) phase_d = '0;
  end

  assign bus.o_fir_en  = (state_q != IDLE);
  assign bus.o_zero_in = (state_q == FLUSH);
  assign bus.o_valid   = (state_q == RUN) || (state_q == FLUSH);
  assign bus.o_phase   = phase_q;
  assign bus.o_strobe  = bus.o_valid && (phase_q == '0);
  assign bus.o_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer: expected outputs queued per
// driven cycle and compared on the falling edge.
module tb_fir_sequencer;
  localparam int NC = 17;
  localparam int PL = 5;
  localparam int OS = 4;
  localparam int FL = NC + PL - 1;

  localparam int S_IDLE  = 0;
  localparam int S_FILL  = 1;
  localparam int S_RUN   = 2;
  localparam int S_FLUSH = 3;

  typedef struct packed {
    logic       fir_en;
    logic       zero_in;
    logic       valid;
    logic [1:0] phase;
    logic       strobe;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_sequencer_if #(.OS_FACTOR(OS)) bus ();

  fir_sequencer #(
    .NUM_COEFF(NC),
    .PIPE_LAT (PL),
    .OS_FACTOR(OS)
  ) dut (
    .clk    (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t e_m;
  int   vectors    = 0;
  int   miscompares = 0;
  int   ph_m = 0;
  int   s_m  = S_IDLE;
  int   nstb;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(int s, int ph);
    exp_t e;
    e.fir_en  = (s != S_IDLE);
    e.zero_in = (s == S_FLUSH);
    e.valid   = (s == S_RUN) || (s == S_FLUSH);
    e.phase   = 2'(ph);
    e.strobe  = e.valid && (ph == 0);
    e.busy    = (s != S_IDLE);
    return e;
  endfunction

  // Drive one cycle; s is the state the spec requires after this edge.
  task automatic step(bit st, bit sp, bit rs, int s);
    bus.i_start = st;
    bus.i_stop  = sp;
    rst         = rs;
    if (s == S_IDLE || s_m == S_IDLE) ph_m = 0;
    else ph_m = (ph_m + 1) % OS;
    s_m = s;
    @(posedge clk);
    exp_q.push_back(mk(s, ph_m));
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      check_eq("fir_en",  bus.o_fir_en,  e_m.fir_en);
      check_eq("zero_in", bus.o_zero_in, e_m.zero_in);
      check_eq("valid",   bus.o_valid,   e_m.valid);
      check_eq("phase",   bus.o_phase,   e_m.phase);
      check_eq("strobe",  bus.o_strobe,  e_m.strobe);
      check_eq("busy",    bus.o_busy,    e_m.busy);
    end
  end

  task automatic fill_to_run();
    step(1, 0, 0, S_FILL);
    repeat (PL - 1) step(0, 0, 0, S_FILL);
    step(0, 0, 0, S_RUN);
    check_eq("first_run_phase", bus.o_phase, PL % OS);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;

    // reset dominates start/stop; stop alone in IDLE is ignored
    step(1, 1, 1, S_IDLE);
    step(1, 1, 1, S_IDLE);
    step(0, 1, 0, S_IDLE);
    step(0, 1, 0, S_IDLE);

    // normal start, then 40 RUN cycles with a stray start
    fill_to_run();
    nstb = 0;
    for (int i = 0; i < 39; i++) begin
      step(i == 7, 0, 0, S_RUN);
      if (bus.o_strobe) nstb++;
    end
    step(0, 0, 0, S_RUN);
    if (bus.o_strobe) nstb++;
    check_eq("run_strobes_40", nstb, 10);

    // stop -> full zero flush, then idle
    step(0, 1, 0, S_FLUSH);
    repeat (FL - 1) step(0, 0, 0, S_FLUSH);
    step(0, 0, 0, S_IDLE);
    step(0, 0, 0, S_IDLE);

    // start+stop in IDLE -> FILL; stop on third FILL cycle aborts
    step(1, 1, 0, S_FILL);
    step(0, 0, 0, S_FILL);
    step(0, 0, 0, S_FILL);
    step(0, 1, 0, S_IDLE);
    repeat (3) step(0, 0, 0, S_IDLE);

    // start+stop in FILL: stop wins
    step(1, 0, 0, S_FILL);
    step(1, 1, 0, S_IDLE);
    step(0, 0, 0, S_IDLE);

    // start+stop in RUN -> FLUSH; inputs ignored in flush; held start restarts
    fill_to_run();
    repeat (3) step(0, 0, 0, S_RUN);
    step(1, 1, 0, S_FLUSH);
    for (int i = 0; i < FL - 1; i++) step(1, i[0], 0, S_FLUSH);
    step(1, 0, 0, S_IDLE);
    step(1, 0, 0, S_FILL);
    repeat (PL - 1) step(0, 0, 0, S_FILL);
    step(0, 0, 0, S_RUN);

    // reset mid-FLUSH from RUN carried over, then reset mid-FILL
    step(0, 1, 0, S_FLUSH);
    step(1, 1, 1, S_IDLE);
    step(1, 0, 0, S_FILL);
    step(0, 0, 0, S_FILL);
    step(1, 1, 1, S_IDLE);
    step(0, 0, 0, S_IDLE);

    // reset on the tenth FLUSH cycle, then a normal fill
    fill_to_run();
    step(0, 1, 0, S_FLUSH);
    repeat (9) step(0, 0, 0, S_FLUSH);
    step(1, 0, 1, S_IDLE);
    check_eq("rst_flush_busy", bus.o_busy, 0);
    step(0, 0, 0, S_IDLE);
    fill_to_run();
    step(0, 1, 0, S_FLUSH);
    repeat (FL - 1) step(0, 0, 0, S_FLUSH);
    step(0, 0, 0, S_IDLE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter NUM_COEFF, default 17, tap count of the sequenced FIR.
REQ-002 SHALL have parameter PIPE_LAT, default 5, FIR latency in enabled cycles from input sample to output register.
REQ-003 SHALL have parameter OS_FACTOR, default 4, oversampling ratio, power of two, >=2.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_start  input  1  start request, single-cycle pulse or level.
REQ-007 SHALL have port i_stop  input  1  stop request, single-cycle pulse or level.
REQ-008 SHALL have port o_fir_en  output  1  drives the FIR i_en; low clears the FIR pipeline.
REQ-009 SHALL have port o_zero_in  output  1  high selects zero instead of sample data at the FIR input.
REQ-010 SHALL have port o_valid  output  1  FIR output is meaningful this cycle.
REQ-011 SHALL have port o_phase  output  $clog2(OS_FACTOR)  oversampling phase counter.
REQ-012 SHALL have port o_strobe  output  1  decimation strobe, high when o_valid and o_phase==0.
REQ-013 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, RUN, FLUSH, all registered; outputs decoded from registered state and counters.
REQ-015 IDLE: o_fir_en=0, o_zero_in=0, o_valid=0, o_phase=0, counter=0; i_start=1 -> FILL next cycle; i_stop ignored.
REQ-016 FILL: o_fir_en=1, o_valid=0; counter increments each cycle from 0; at counter==PIPE_LAT-1 -> RUN, counter cleared.
REQ-017 FILL with i_stop=1 SHALL abort to IDLE next cycle, no o_valid ever asserted.
REQ-018 RUN: o_fir_en=1, o_valid=1, o_zero_in=0; i_stop=1 -> FLUSH next cycle; i_start ignored.
REQ-019 FLUSH: o_fir_en=1, o_zero_in=1, o_valid=1 for exactly NUM_COEFF+PIPE_LAT-1 cycles, then IDLE.
REQ-020 i_start and i_stop SHALL be ignored during FLUSH; i_start held high at FLUSH exit SHALL restart FILL from IDLE one cycle later.
REQ-021 i_start and i_stop high together in IDLE -> FILL; in FILL -> IDLE (stop wins); in RUN -> FLUSH.
REQ-022 o_phase SHALL increment modulo OS_FACTOR every cycle o_fir_en=1, wrap OS_FACTOR-1 -> 0, and clear to 0 in IDLE.
REQ-023 o_phase SHALL be 0 on the first FILL cycle, so the first RUN cycle phase equals PIPE_LAT mod OS_FACTOR.
REQ-024 counter width SHALL be $clog2(NUM_COEFF+PIPE_LAT)+1 bits; no overflow for any legal parameters.
REQ-025 FILL to RUN transition SHALL occur exactly PIPE_LAT cycles after the cycle o_fir_en first goes high.
REQ-026 o_busy SHALL equal (state != IDLE) with no extra cycle of lag.

Reset
REQ-027 i_reset=1 at a rising clk edge SHALL force state IDLE, counter 0, o_phase 0; all outputs 0 the following cycle.
REQ-028 reset SHALL take priority over i_start and i_stop in every state, including mid-FILL and mid-FLUSH.
REQ-029 no asynchronous reset path; outputs SHALL not change between clock edges.

Verification
REQ-030 Default params, i_start pulse in IDLE -> o_fir_en high next cycle, o_valid rises exactly 5 cycles later, o_phase=1 at the first valid cycle.
REQ-031 In RUN, i_stop pulse -> o_zero_in high 21 cycles with o_valid high, then o_busy=0 and o_fir_en=0.
REQ-032 i_stop on third FILL cycle -> IDLE next cycle, o_valid never asserted.
REQ-033 i_start and i_stop same cycle in IDLE -> FILL; same in RUN -> FLUSH.
REQ-034 i_reset pulse at the tenth FLUSH cycle -> all outputs 0 next cycle; later i_start gives the normal 5-cycle fill.
REQ-035 OS_FACTOR=4, RUN held 40 cycles -> o_strobe exactly every 4th cycle, o_phase sequence 0,1,2,3 wraps with no gaps.
